// File: rtl/pwm_trip_guard.sv
// pwm_trip_guard
//   Protection stage between the PWM generator's A/B pairs and the gate-driver
//   pins. It passes PWM through while running. Any of three causes forces all
//   outputs to the safe levels and latches a trip:
//     - a filtered external driver fault,
//     - a two-edge shoot-through overlap,
//     - a software trip.
//   Leaving the trip takes an accepted clear (TRIPPED -> REARM) followed by a
//   cycle in which every PWM input is at its safe level (REARM -> RUN).
//
// Ports
//   clk, reset              clock; synchronous active-high reset
//   pwm_in_A/B   [N_LEGS]   PWM stage outputs (bit i = leg i+1)
//   safe_level_A/B          safe level for all A / all B outputs
//   fault_n                 asynchronous active-low driver fault
//   filt_len  [FILT_WIDTH]  qualifying fault length in synced cycles (0 -> 1)
//   st_enable               enables shoot-through detection
//   sw_trip, trip_clear     software trip request / clear request
//   pwm_out_A/B  [N_LEGS]   registered guarded outputs
//   tripped                 state is not RUN
//   trip_cause [2:0]        sticky {sw, shoot-through, external}
//   trip_irq                one-cycle pulse on entry to TRIPPED

// Per-leg compare against the safe levels.
module pwm_trip_leg (
  input  logic a,
  input  logic b,
  input  logic safe_a,
  input  logic safe_b,
  output logic overlap,
  output logic idle
);
  assign overlap = (a ^ safe_a) & (b ^ safe_b);
  assign idle    = ~(a ^ safe_a) & ~(b ^ safe_b);
endmodule

module pwm_trip_guard #(
  parameter int N_LEGS     = 4,
  parameter int FILT_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [N_LEGS-1:0]     pwm_in_A,
  input  logic [N_LEGS-1:0]     pwm_in_B,
  input  logic                  safe_level_A,
  input  logic                  safe_level_B,
  input  logic                  fault_n,
  input  logic [FILT_WIDTH-1:0] filt_len,
  input  logic                  st_enable,
  input  logic                  sw_trip,
  input  logic                  trip_clear,
  output logic [N_LEGS-1:0]     pwm_out_A,
  output logic [N_LEGS-1:0]     pwm_out_B,
  output logic                  tripped,
  output logic [2:0]            trip_cause,
  output logic                  trip_irq
);

  typedef enum logic [1:0] {RUN = 2'd0, TRIPPED = 2'd1, REARM = 2'd2} state_t;

  state_t state, state_nxt;

  // ---------------- fault path ----------------
  logic [1:0]            fault_sync;   // [1] is the synchronized fault
  logic                  fault_s;
  logic [FILT_WIDTH-1:0] filt_n, flt_cnt;
  logic                  flt_qual;

  always_ff @(posedge clk) begin
    if (reset) fault_sync <= '0;
    else       fault_sync <= {fault_sync[0], ~fault_n};
  end
  assign fault_s = fault_sync[1];

  assign filt_n = (filt_len == '0) ? FILT_WIDTH'(1) : filt_len;

  // Clamping to filt_n (rather than holding) lets a shortened filt_len
  // take hold against the current count.
  always_ff @(posedge clk) begin
    if (reset)               flt_cnt <= '0;
    else if (!fault_s)       flt_cnt <= '0;
    else if (flt_cnt < filt_n) flt_cnt <= flt_cnt + 1'b1;
    else                     flt_cnt <= filt_n;
  end
  assign flt_qual = (flt_cnt >= filt_n);

  // ---------------- shoot-through path ----------------
  logic [N_LEGS-1:0] leg_ov, leg_idle;
  logic              st_raw, st_prev, st_trip, all_idle;

  for (genvar i = 0; i < N_LEGS; i++) begin : g_leg
    pwm_trip_leg u_leg (
      .a       (pwm_in_A[i]),
      .b       (pwm_in_B[i]),
      .safe_a  (safe_level_A),
      .safe_b  (safe_level_B),
      .overlap (leg_ov[i]),
      .idle    (leg_idle[i])
    );
  end

  assign st_raw   = st_enable & (|leg_ov);
  assign all_idle = &leg_idle;

  always_ff @(posedge clk) begin
    if (reset) st_prev <= 1'b0;
    else       st_prev <= st_raw;
  end
  // A single-edge overlap (e.g. edge skew at a transition) is tolerated.
  assign st_trip = st_raw & st_prev;

  // ---------------- FSM ----------------
  logic trip_now, clr_ok;
  assign trip_now = flt_qual | st_trip | sw_trip;
  // Clear is only honoured once every trip source is quiet; otherwise dropped.
  assign clr_ok   = trip_clear & ~fault_s & ~st_raw & ~sw_trip;

  always_ff @(posedge clk) begin
    if (reset) state <= REARM;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      RUN:     if (trip_now) state_nxt = TRIPPED;
      TRIPPED: if (clr_ok)   state_nxt = REARM;
      REARM: begin
        if (trip_now)      state_nxt = TRIPPED;
        else if (all_idle) state_nxt = RUN;
      end
      default: state_nxt = REARM;
    endcase
  end

  logic pass, irq_set, cause_clr;
  always_comb begin
    pass      = (state_nxt == RUN);
    irq_set   = (state_nxt == TRIPPED) && (state != TRIPPED);
    cause_clr = (state == TRIPPED) && (state_nxt == REARM);
    tripped   = (state != RUN);
  end

  // ---------------- registered outputs ----------------
  always_ff @(posedge clk) begin
    if (reset) begin
      pwm_out_A  <= {N_LEGS{safe_level_A}};
      pwm_out_B  <= {N_LEGS{safe_level_B}};
      trip_cause <= '0;
      trip_irq   <= 1'b0;
    end else begin
      pwm_out_A  <= pass ? pwm_in_A : {N_LEGS{safe_level_A}};
      pwm_out_B  <= pass ? pwm_in_B : {N_LEGS{safe_level_B}};
      trip_cause <= cause_clr ? 3'b000 : (trip_cause | {sw_trip, st_trip, flt_qual});
      trip_irq   <= irq_set;
    end
  end

endmodule

// File: tb/tb_pwm_trip_guard.sv
module tb_pwm_trip_guard;
  localparam int NL = 4;
  localparam int FW = 8;

  logic          clk = 1'b0;
  logic          reset;
  logic [NL-1:0] pwm_in_A, pwm_in_B;
  logic          safe_level_A, safe_level_B;
  logic          fault_n;
  logic [FW-1:0] filt_len;
  logic          st_enable, sw_trip, trip_clear;
  logic [NL-1:0] pwm_out_A, pwm_out_B;
  logic          tripped;
  logic [2:0]    trip_cause;
  logic          trip_irq;

  always #5 clk = ~clk;

  pwm_trip_guard #(.N_LEGS(NL), .FILT_WIDTH(FW)) dut (
    .clk(clk), .reset(reset),
    .pwm_in_A(pwm_in_A), .pwm_in_B(pwm_in_B),
    .safe_level_A(safe_level_A), .safe_level_B(safe_level_B),
    .fault_n(fault_n), .filt_len(filt_len), .st_enable(st_enable),
    .sw_trip(sw_trip), .trip_clear(trip_clear),
    .pwm_out_A(pwm_out_A), .pwm_out_B(pwm_out_B),
    .tripped(tripped), .trip_cause(trip_cause), .trip_irq(trip_irq)
  );

  typedef struct {
    logic [NL-1:0] a, b;
    logic          t;
    logic [2:0]    c;
    logic          i;
    string         nm;
  } exp_t;

  exp_t exp_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  // Monitor: one expected response per clock edge, checked just after it.
  always @(posedge clk) begin
    #1;
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      n_tests++;
      if (pwm_out_A !== e.a || pwm_out_B !== e.b || tripped !== e.t ||
          trip_cause !== e.c || trip_irq !== e.i) begin
        n_fail++;
        $display("FAIL %s: got A=%h B=%h tripped=%b cause=%b irq=%b, want A=%h B=%h tripped=%b cause=%b irq=%b",
                 e.nm, pwm_out_A, pwm_out_B, tripped, trip_cause, trip_irq,
                 e.a, e.b, e.t, e.c, e.i);
      end
    end
  end

  // Drive pwm inputs for the next edge and queue the response expected after it.
  task automatic cyc(input logic [NL-1:0] a, input logic [NL-1:0] b,
                     input logic [NL-1:0] ea, input logic [NL-1:0] eb,
                     input logic et, input logic [2:0] ec, input logic ei,
                     input string nm);
    exp_t e;
    pwm_in_A = a;
    pwm_in_B = b;
    e.a = ea; e.b = eb; e.t = et; e.c = ec; e.i = ei; e.nm = nm;
    exp_q.push_back(e);
    @(negedge clk);
  endtask

  task automatic rep(input int n, input logic [NL-1:0] a, input logic [NL-1:0] b,
                     input logic [NL-1:0] ea, input logic [NL-1:0] eb,
                     input logic et, input logic [2:0] ec, input logic ei,
                     input string nm);
    for (int k = 0; k < n; k++) cyc(a, b, ea, eb, et, ec, ei, nm);
  endtask

  initial begin
    reset = 1'b1; pwm_in_A = '0; pwm_in_B = '0;
    safe_level_A = 1'b0; safe_level_B = 1'b0;
    fault_n = 1'b1; filt_len = 8'd5; st_enable = 1'b1;
    sw_trip = 1'b0; trip_clear = 1'b0;

    // reset and release
    rep(2, 4'h0, 4'h0, 4'h0, 4'h0, 1, 3'b000, 0, "reset");
    reset = 1'b0;
    cyc(4'h0, 4'h0, 4'h0, 4'h0, 0, 3'b000, 0, "rearm_to_run");
    cyc(4'h5, 4'h0, 4'h5, 4'h0, 0, 3'b000, 0, "pass1");
    cyc(4'h0, 4'hA, 4'h0, 4'hA, 0, 3'b000, 0, "pass2");
    cyc(4'h1, 4'h2, 4'h1, 4'h2, 0, 3'b000, 0, "pass3");

    // fault glitch: 4 lows with N=5
    fault_n = 1'b0;
    rep(4, 4'h0, 4'h0, 4'h0, 4'h0, 0, 3'b000, 0, "glitch");
    fault_n = 1'b1;
    rep(4, 4'h0, 4'h0, 4'h0, 4'h0, 0, 3'b000, 0, "glitch_rec");

    // held fault: trip 7 edges after the first low sample
    fault_n = 1'b0;
    rep(7, 4'h3, 4'h0, 4'h3, 4'h0, 0, 3'b000, 0, "flt_run");
    cyc(4'h3, 4'h0, 4'h0, 4'h0, 1, 3'b001, 1, "flt_trip");
    cyc(4'h3, 4'h0, 4'h0, 4'h0, 1, 3'b001, 0, "flt_hold");

    // clear ignored while fault still present
    trip_clear = 1'b1;
    cyc(4'h0, 4'h0, 4'h0, 4'h0, 1, 3'b001, 0, "clr_ignored");
    trip_clear = 1'b0;
    fault_n = 1'b1;
    rep(3, 4'h0, 4'h0, 4'h0, 4'h0, 1, 3'b001, 0, "flt_release");

    // accepted clear, rearm waits for idle PWM
    trip_clear = 1'b1;
    cyc(4'h1, 4'h0, 4'h0, 4'h0, 1, 3'b000, 0, "clr_accept");
    trip_clear = 1'b0;
    rep(2, 4'h1, 4'h0, 4'h0, 4'h0, 1, 3'b000, 0, "rearm_wait");
    cyc(4'h0, 4'h0, 4'h0, 4'h0, 0, 3'b000, 0, "rearm_run");
    cyc(4'h2, 4'h0, 4'h2, 4'h0, 0, 3'b000, 0, "run_pass");

    // shoot-through on leg 3
    cyc(4'h4, 4'h4, 4'h4, 4'h4, 0, 3'b000, 0, "st_1edge");
    cyc(4'h0, 4'h0, 4'h0, 4'h0, 0, 3'b000, 0, "st_1edge_ok");
    cyc(4'h4, 4'h4, 4'h4, 4'h4, 0, 3'b000, 0, "st_edge1");
    cyc(4'h4, 4'h4, 4'h0, 4'h0, 1, 3'b010, 1, "st_trip");
    cyc(4'h0, 4'h0, 4'h0, 4'h0, 1, 3'b010, 0, "st_hold");
    trip_clear = 1'b1;
    cyc(4'h0, 4'h0, 4'h0, 4'h0, 1, 3'b000, 0, "st_clr");
    trip_clear = 1'b0;
    cyc(4'h0, 4'h0, 4'h0, 4'h0, 0, 3'b000, 0, "st_run");

    // detection disabled
    st_enable = 1'b0;
    rep(3, 4'h4, 4'h4, 4'h4, 4'h4, 0, 3'b000, 0, "st_dis");
    st_enable = 1'b1;
    cyc(4'h0, 4'h0, 4'h0, 4'h0, 0, 3'b000, 0, "st_dis_end");

    // software trip with clear in the same cycle
    sw_trip = 1'b1;
    cyc(4'h0, 4'h0, 4'h0, 4'h0, 1, 3'b100, 1, "sw_trip");
    trip_clear = 1'b1;
    cyc(4'h0, 4'h0, 4'h0, 4'h0, 1, 3'b100, 0, "sw_clr_same");
    sw_trip = 1'b0; trip_clear = 1'b0;
    cyc(4'h0, 4'h0, 4'h0, 4'h0, 1, 3'b100, 0, "sw_hold");
    trip_clear = 1'b1;
    cyc(4'h1, 4'h0, 4'h0, 4'h0, 1, 3'b000, 0, "sw_clr");
    trip_clear = 1'b0;

    // trip during REARM outranks the idle rearm
    cyc(4'h1, 4'h0, 4'h0, 4'h0, 1, 3'b000, 0, "rearm_hold");
    sw_trip = 1'b1;
    cyc(4'h0, 4'h0, 4'h0, 4'h0, 1, 3'b100, 1, "rearm_trip");
    sw_trip = 1'b0;
    cyc(4'h0, 4'h0, 4'h0, 4'h0, 1, 3'b100, 0, "retrip_hold");

    // reset mid-TRIPPED with safe A level = 1
    safe_level_A = 1'b1; reset = 1'b1;
    cyc(4'hF, 4'h0, 4'hF, 4'h0, 1, 3'b000, 0, "rst_mid");
    reset = 1'b0;
    cyc(4'hF, 4'h0, 4'hF, 4'h0, 0, 3'b000, 0, "rst_run");

    // filt_len = 0 behaves as 1: trip 3 edges after the first low sample
    filt_len = 8'd0; fault_n = 1'b0;
    rep(3, 4'hE, 4'h0, 4'hE, 4'h0, 0, 3'b000, 0, "f1_run");
    cyc(4'hE, 4'h0, 4'hF, 4'h0, 1, 3'b001, 1, "f1_trip");

    // let the monitor drain the last entries
    for (int k = 0; k < 20 && exp_q.size() > 0; k++) @(negedge clk);
    if (exp_q.size() != 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL drain: got %0d pending, want 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
